hazard_sequencer: RTL

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_match.sv | 17 +
 rtl/hazard_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard sequencer: FSM states, operand-mux encodings, pipeline slot.
// Latency: none (types and constants only).
// Backpressure: none.
package hazard_pkg;

   // Widest register address a slot can carry; narrower REG_AW values are zero-extended.
   localparam int SLOT_RD_W = 8;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      FLUSH      = 2'd3
   } hz_state_t;

   // EX operand-mux selects; bit 1 (execute stage) overrides bit 0 (memory stage).
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_EX  = 2'b10;

   typedef struct packed {
      logic [SLOT_RD_W-1:0] rd;
      logic                 regwrite;
      logic                 memread;
      logic                 memop;
   } slot_t;

endpackage

// File: rtl/hazard_match.sv
// One pipeline slot versus one source register: does the slot produce that register?
// Latency: purely combinational.
// Backpressure: none.
// Ports: slot_rd/slot_regwrite describe the slot, src is the source register, hit is the match.
module hazard_match
   import hazard_pkg::*;
(
   input  logic [SLOT_RD_W-1:0] slot_rd,
   input  logic                 slot_regwrite,
   input  logic [SLOT_RD_W-1:0] src,
   output logic                 hit
);

   // r0 is hardwired to zero, so a write to it never produces a forwardable value.
   assign hit = slot_regwrite && (slot_rd == src) && (slot_rd != '0);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stall, branch flush, data-memory wait, forwarding selects.
// Latency: holds/flush/bubble combinational in the same cycle; fwd_sel registered, valid in EX cycle.
// Backpressure: dmem_ready low with a memory op in MEM freezes every slot and select (MEM_WAIT).
// Ports: clk/rst_n; id_* describe the ID instruction; branch_taken, dmem_ready are pipeline events;
//        pc_hold/ifid_hold/ifid_flush/idex_bubble drive pipeline registers; fwd_sel_a/b drive
//        the EX operand muxes; state is the FSM state.
//        Define HAZARD_PERF_CNT_EN to add saturating stall_cnt and flush_cnt outputs.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memop,
   input  logic              branch_taken,
   input  logic              dmem_ready,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [1:0]        fwd_sel_a,
   output logic [1:0]        fwd_sel_b,
   output logic [1:0]        state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   hz_state_t            state_q, state_d;
   slot_t                ex_q, mem_q, wb_q, id_slot;
   logic [SLOT_RD_W-1:0] rs1_x, rs2_x;
   logic                 hit_a_ex, hit_a_mem, hit_b_ex, hit_b_mem;
   logic                 load_use, mem_block, advance;

   assign rs1_x   = SLOT_RD_W'(id_rs1);
   assign rs2_x   = SLOT_RD_W'(id_rs2);
   assign id_slot = '{rd: SLOT_RD_W'(id_rd), regwrite: id_regwrite,
                      memread: id_memread, memop: id_memop};

   hazard_match u_match_a_ex  (.slot_rd(ex_q.rd),  .slot_regwrite(ex_q.regwrite),  .src(rs1_x), .hit(hit_a_ex));
   hazard_match u_match_a_mem (.slot_rd(mem_q.rd), .slot_regwrite(mem_q.regwrite), .src(rs1_x), .hit(hit_a_mem));
   hazard_match u_match_b_ex  (.slot_rd(ex_q.rd),  .slot_regwrite(ex_q.regwrite),  .src(rs2_x), .hit(hit_b_ex));
   hazard_match u_match_b_mem (.slot_rd(mem_q.rd), .slot_regwrite(mem_q.regwrite), .src(rs2_x), .hit(hit_b_mem));

   assign load_use  = id_valid && ex_q.memread && (hit_a_ex || hit_b_ex);
   assign mem_block = mem_q.memop && !dmem_ready;
   // Only the MEM_WAIT state freezes the pipe; the cycle that detects the wait still advances.
   assign advance   = (state_q != MEM_WAIT);
   assign state     = state_q;

   // Priority inside the non-wait states: memory wait, then branch flush, then load-use.
   always_comb begin
      state_d     = state_q;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      case (state_q)
         MEM_WAIT: begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            if (dmem_ready) state_d = RUN;
         end
         default: begin
            if (mem_block) begin
               state_d = MEM_WAIT;
            end else if (branch_taken && (state_q != FLUSH)) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               state_d     = FLUSH;
            end else if (load_use && (state_q == RUN)) begin
               pc_hold     = 1'b1;
               ifid_hold   = 1'b1;
               idex_bubble = 1'b1;
               state_d     = LOAD_STALL;
            end else begin
               state_d = RUN;
            end
         end
      endcase
      // Controls must read zero for the whole reset interval, whatever the inputs do.
      if (!rst_n) begin
         pc_hold     = 1'b0;
         ifid_hold   = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         fwd_sel_a <= FWD_RF;
         fwd_sel_b <= FWD_RF;
      end else begin
         state_q <= state_d;
         if (advance) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (idex_bubble) begin
               ex_q      <= '0;
               fwd_sel_a <= FWD_RF;
               fwd_sel_b <= FWD_RF;
            end else begin
               ex_q      <= id_slot;
               fwd_sel_a <= {hit_a_ex, hit_a_mem};
               fwd_sel_b <= {hit_b_ex, hit_b_mem};
            end
         end
      end
   end

   // Slot fields no decision consults (WB slot, EX memop, MEM memread) are gathered here.
   logic unused_slot_bits;
   assign unused_slot_bits = ^{wb_q, ex_q.memop, mem_q.memread};

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_hold && (stall_cnt != '1))    stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule
